serial_adder_resp: RTL and testbench

//   Handshaked, bit-serial, multi-cycle adder: the responder for the operand-driving

---
 rtl/serial_adder_resp.sv | 111 +++++++++++
 tb/tb_serial_adder_resp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_resp.sv
// rtl/serial_adder_resp.sv - handshaked bit-serial adder returning {carry, sum} on a valid/ready channel
module serial_adder_resp #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  // Bit index needs at least one bit even when WIDTH == 1.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_carry;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [WIDTH:0]     r_out;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_op_count;

  logic               w_s;
  logic               w_carry_next;
  logic [WIDTH:0]     w_sum_cat;
  logic [WIDTH-1:0]   w_sum_next;

  // One full-adder slice on the current LSBs; the new sum bit enters from the MSB side
  // so that after WIDTH shifts the sum register holds the result in natural order.
  assign w_s          = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry_next = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
  assign w_sum_cat    = {w_s, r_sum_sh};
  assign w_sum_next   = w_sum_cat[WIDTH:1];

  // Handshake readiness and activity are pure state decode; no input reaches an output.
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign op_count  = r_op_count;

  // Control FSM and serial datapath: accept, shift-add WIDTH bits, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_carry     <= 1'b0;
      r_bit_idx   <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_carry   <= c_in;
            r_sum_sh  <= '0;
            r_bit_idx <= '0;
            r_state   <= S_ADD;
          end
        end
        S_ADD: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_carry   <= w_carry_next;
          r_sum_sh  <= w_sum_next;
          r_bit_idx <= r_bit_idx + 1'b1;
          if (r_bit_idx == LAST_IDX) begin
            r_out       <= {w_carry_next, w_sum_next};
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Result and valid stay frozen under backpressure; out keeps its value after the handshake.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_op_count  <= r_op_count + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_resp.sv
// tb/tb_serial_adder_resp.sv - directed self-checking bench for serial_adder_resp
module tb_serial_adder_resp;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_pass;
  int n_total;

  serial_adder_resp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents a request at a negedge once in_ready is seen; returns #1 after the accept edge.
  task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic vc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      a = va;
      b = vb;
      c_in = vc;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Counts accept-to-valid edges; returns #1 after the edge that raised out_valid.
  task automatic wait_resp(output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out !== 5'd0) $display("FAIL reset_out got %0d want 0", out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (op_count !== 8'd0) $display("FAIL reset_op_count got %0d want 0", op_count); else n_pass++;
  endtask

  task automatic test_basic();
    bit to;
    int lat;
    out_ready = 1'b1;
    send(4'd9, 4'd7, 1'b1, to);
    n_total++; if (to) $display("FAIL basic_accept got timeout want accept"); else n_pass++;
    n_total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); else n_pass++;
    wait_resp(lat, to);
    n_total++; if (to || lat != 4) $display("FAIL basic_latency got %0d (timeout=%0b) want 4", lat, to); else n_pass++;
    n_total++; if (out !== 5'd17) $display("FAIL basic_sum got %0d want 17", out); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    n_total++; if (op_count !== 8'd1) $display("FAIL basic_op_count got %0d want 1", op_count); else n_pass++;
    n_total++; if (out !== 5'd17) $display("FAIL basic_out_retained got %0d want 17", out); else n_pass++;
  endtask

  task automatic test_extremes();
    bit to;
    int lat;
    do_reset();
    out_ready = 1'b1;
    send(4'd15, 4'd15, 1'b1, to);
    wait_resp(lat, to);
    n_total++; if (to || out !== 5'd31) $display("FAIL max_sum got %0d (timeout=%0b) want 31", out, to); else n_pass++;
    send(4'd0, 4'd0, 1'b0, to);
    wait_resp(lat, to);
    n_total++; if (to || out !== 5'd0) $display("FAIL zero_sum got %0d (timeout=%0b) want 0", out, to); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (op_count !== 8'd2) $display("FAIL two_ops_count got %0d want 2", op_count); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    int lat;
    out_ready = 1'b0;
    send(4'd5, 4'd10, 1'b0, to);
    wait_resp(lat, to);
    n_total++; if (to || out !== 5'd15) $display("FAIL bp_sum got %0d (timeout=%0b) want 15", out, to); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b1 || out !== 5'd15 || in_ready !== 1'b0)
        $display("FAIL bp_hold cycle %0d got valid=%b out=%0d in_ready=%b want 1/15/0", i, out_valid, out, in_ready);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
    n_total++; if (op_count !== 8'd3) $display("FAIL bp_op_count got %0d want 3", op_count); else n_pass++;
  endtask

  task automatic test_ignore_inputs();
    bit to;
    out_ready = 1'b1;
    send(4'd3, 4'd4, 1'b0, to);
    for (int i = 0; i < 3; i++) begin
      a = 4'd12;
      b = 4'd1;
      c_in = 1'b1;
      in_valid = (i != 1);
      @(posedge clk); #1;
      n_total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL ign_add cycle %0d got in_ready=%b valid=%b want 0/0", i, in_ready, out_valid);
      else n_pass++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || out !== 5'd7) $display("FAIL ign_sum got valid=%b out=%0d want 1/7", out_valid, out); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL ign_done_ready got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL ign_release got in_ready=%b busy=%b want 1/0", in_ready, busy); else n_pass++;
  endtask

  task automatic test_reset_mid_add();
    bit to;
    int lat;
    out_ready = 1'b1;
    send(4'd6, 4'd6, 1'b0, to);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out !== 5'd0 || op_count !== 8'd0 || busy !== 1'b0)
      $display("FAIL midrst_clear got valid=%b out=%0d cnt=%0d busy=%b want 0/0/0/0", out_valid, out, op_count, busy);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else n_pass++;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n_total++;
        $display("FAIL midrst_spurious got out_valid=1 want 0");
      end
    end
    send(4'd1, 4'd2, 1'b0, to);
    wait_resp(lat, to);
    n_total++; if (to || lat != 4 || out !== 5'd3) $display("FAIL midrst_next got out=%0d lat=%0d want 3/4", out, lat); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int issued;
    int done;
    int cyc;
    int last_acc;
    int bad_gap;
    int bad_sum;
    int va;
    int vb;
    int vc;
    int want;
    do_reset();
    out_ready = 1'b1;
    issued = 0;
    done = 0;
    cyc = 0;
    last_acc = -1;
    bad_gap = 0;
    bad_sum = 0;
    while (done < 300 && cyc < 300 * 6 + 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        want = exp_q.pop_front();
        if (out !== want[WIDTH:0]) begin
          bad_sum++;
          if (bad_sum <= 5) $display("FAIL b2b_sum op %0d got %0d want %0d", done, out, want);
        end
        done++;
      end
      if (in_ready && issued < 300) begin
        va = $urandom_range(0, 15);
        vb = $urandom_range(0, 15);
        vc = $urandom_range(0, 1);
        a = va[WIDTH-1:0];
        b = vb[WIDTH-1:0];
        c_in = vc[0];
        in_valid = 1'b1;
        exp_q.push_back(va + vb + vc);
        if (last_acc >= 0 && cyc - last_acc != 6) bad_gap++;
        last_acc = cyc;
        issued++;
      end else begin
        in_valid = 1'b0;
      end
    end
    n_total++; if (done != 300) $display("FAIL b2b_complete got %0d want 300", done); else n_pass++;
    n_total++; if (bad_sum != 0) $display("FAIL b2b_mismatches got %0d want 0", bad_sum); else n_pass++;
    n_total++; if (bad_gap != 0) $display("FAIL b2b_spacing got %0d bad gaps want 0", bad_gap); else n_pass++;
    @(negedge clk);
    n_total++; if (op_count !== 8'd44) $display("FAIL b2b_op_count got %0d want 44", op_count); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_add();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
